// File: rtl/tank_sprite_scheduler.sv
// Two-tank sprite scheduler: box test, single ROM port arbitration,
// two-cycle pixel pipeline and frame-synchronous position updates.

module tank_sprite_scheduler #(
    parameter int unsigned SPR_DIM    = 32,
    parameter int unsigned H_LAST     = 639,
    parameter int unsigned V_LAST     = 479,
    parameter logic [3:0]  TRANSP_IDX = 4'h0
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic [9:0]  t1_x,
    input  logic [9:0]  t1_y,
    input  logic [9:0]  t2_x,
    input  logic [9:0]  t2_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    output logic [10:0] rom_address,
    input  logic [3:0]  rom_q,
    output logic [3:0]  pix_idx,
    output logic        pix_hit,
    output logic [1:0]  pix_src,
    output logic        collide
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] cur1_x_q, cur1_y_q, cur2_x_q, cur2_y_q;
    logic [9:0] cur1_x_d, cur1_y_d, cur2_x_d, cur2_y_d;
    logic [9:0] sh1_x_q, sh1_y_q, sh2_x_q, sh2_y_q;
    logic [9:0] sh1_x_d, sh1_y_d, sh2_x_d, sh2_y_d;

    logic       frame_end;
    logic       in1, in2, overlap;
    logic [1:0] grant;
    logic [4:0] rel_x, rel_y;
    logic [1:0] grant_q;
    logic       blank_q;
    logic [3:0] pix_idx_d;
    logic       pix_hit_d;
    logic [1:0] pix_src_d;
    logic       ovl_q, ovl_d, collide_d;

    assign frame_end = (DrawX == 10'(H_LAST)) && (DrawY == 10'(V_LAST));

    // Update FSM: capture into shadow, hold until frame end, then commit
    always_comb begin
        state_d   = state_q;
        pos_ready = 1'b0;
        cur1_x_d  = cur1_x_q;
        cur1_y_d  = cur1_y_q;
        cur2_x_d  = cur2_x_q;
        cur2_y_d  = cur2_y_q;
        sh1_x_d   = sh1_x_q;
        sh1_y_d   = sh1_y_q;
        sh2_x_d   = sh2_x_q;
        sh2_y_d   = sh2_y_q;
        unique case (state_q)
            IDLE: begin
                pos_ready = 1'b1;
                if (pos_valid) begin
                    sh1_x_d = t1_x;
                    sh1_y_d = t1_y;
                    sh2_x_d = t2_x;
                    sh2_y_d = t2_y;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_end) state_d = COMMIT;
            end
            COMMIT: begin
                cur1_x_d = sh1_x_q;
                cur1_y_d = sh1_y_q;
                cur2_x_d = sh2_x_q;
                cur2_y_d = sh2_y_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, live and shadow position registers
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cur1_x_q <= 10'd64;
            cur1_y_q <= 10'd224;
            cur2_x_q <= 10'd544;
            cur2_y_q <= 10'd224;
            sh1_x_q  <= 10'd64;
            sh1_y_q  <= 10'd224;
            sh2_x_q  <= 10'd544;
            sh2_y_q  <= 10'd224;
        end else begin
            state_q  <= state_d;
            cur1_x_q <= cur1_x_d;
            cur1_y_q <= cur1_y_d;
            cur2_x_q <= cur2_x_d;
            cur2_y_q <= cur2_y_d;
            sh1_x_q  <= sh1_x_d;
            sh1_y_q  <= sh1_y_d;
            sh2_x_q  <= sh2_x_d;
            sh2_y_q  <= sh2_y_d;
        end
    end

    // Box tests in 11 bits so boxes near 1023 do not wrap
    assign in1 = ({1'b0, DrawX} >= {1'b0, cur1_x_q})
              && ({1'b0, DrawX} <  {1'b0, cur1_x_q} + 11'(SPR_DIM))
              && ({1'b0, DrawY} >= {1'b0, cur1_y_q})
              && ({1'b0, DrawY} <  {1'b0, cur1_y_q} + 11'(SPR_DIM));
    assign in2 = ({1'b0, DrawX} >= {1'b0, cur2_x_q})
              && ({1'b0, DrawX} <  {1'b0, cur2_x_q} + 11'(SPR_DIM))
              && ({1'b0, DrawY} >= {1'b0, cur2_y_q})
              && ({1'b0, DrawY} <  {1'b0, cur2_y_q} + 11'(SPR_DIM));
    assign overlap = blank && in1 && in2;

    // Fixed-priority ROM grant: tank1 wins when both boxes cover the pixel
    always_comb begin
        grant = 2'b00;
        if (in1)      grant = 2'b01;
        else if (in2) grant = 2'b10;
    end

    assign rel_x = DrawX[4:0] - (grant[1] ? cur2_x_q[4:0] : cur1_x_q[4:0]);
    assign rel_y = DrawY[4:0] - (grant[1] ? cur2_y_q[4:0] : cur1_y_q[4:0]);
    assign rom_address = ((grant != 2'b00) && blank)
                       ? {grant[1], rel_y, rel_x} : 11'h000;

    // Output decode of the delayed grant against the returned ROM data
    always_comb begin
        pix_idx_d = 4'h0;
        pix_hit_d = 1'b0;
        pix_src_d = 2'b00;
        if ((grant_q != 2'b00) && blank_q) begin
            pix_src_d = grant_q;
            pix_idx_d = rom_q;
            pix_hit_d = (rom_q != TRANSP_IDX);
        end
    end

    // Overlap sticky flag, reported once at frame end
    always_comb begin
        ovl_d     = ovl_q | overlap;
        collide_d = 1'b0;
        if (frame_end) begin
            ovl_d     = 1'b0;
            collide_d = ovl_q | overlap;
        end
    end

    // Pixel pipeline and collision registers, no stall
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= 2'b00;
            blank_q <= 1'b0;
            pix_idx <= 4'h0;
            pix_hit <= 1'b0;
            pix_src <= 2'b00;
            ovl_q   <= 1'b0;
            collide <= 1'b0;
        end else begin
            grant_q <= grant;
            blank_q <= blank;
            pix_idx <= pix_idx_d;
            pix_hit <= pix_hit_d;
            pix_src <= pix_src_d;
            ovl_q   <= ovl_d;
            collide <= collide_d;
        end
    end

endmodule

// File: doc/tank_sprite_scheduler.md
TANK_SPRITE_SCHEDULER -- requirements
Module: tank_sprite_scheduler

Interface
REQ-001 SHALL have parameter SPR_DIM, default 32, meaning sprite width and height in pixels.
REQ-002 SHALL have parameter H_LAST, default 639, meaning last active DrawX.
REQ-003 SHALL have parameter V_LAST, default 479, meaning last active DrawY.
REQ-004 SHALL have parameter TRANSP_IDX, default 4'h0, meaning transparent palette index.
REQ-005 SHALL have a single clock and an asynchronous, active-low reset: vga_clk in 1 (pixel clock, all state on rising edge); reset_n in 1 (async assert, active-low).
REQ-006 SHALL have DrawX in 10 and DrawY in 10, the current pixel coordinate.
REQ-007 SHALL have blank in 1, high = active display region.
REQ-008 SHALL have t1_x, t1_y, t2_x, t2_y in 10 each, the requested top-left positions of tank1 and tank2.
REQ-009 SHALL have pos_valid in 1 and pos_ready out 1, the position-update handshake.
REQ-010 SHALL have rom_address out 11 = {sprite_id, row[4:0], col[4:0]} into a shared sprite ROM.
REQ-011 SHALL have rom_q in 4, the ROM data, valid one cycle after rom_address.
REQ-012 SHALL have pix_idx out 4 (palette index), pix_hit out 1 (opaque sprite pixel) and pix_src out 2 (00 none, 01 tank1, 10 tank2).
REQ-013 SHALL have collide out 1, a one-cycle per-frame pulse when the tank boxes overlap.

Function
REQ-014 Live tank positions SHALL be registers cur1_x/y and cur2_x/y; only these drive hit tests.
- Requested positions SHALL be captured into shadow registers when pos_valid && pos_ready.

REQ-015 Update FSM states SHALL be IDLE, PENDING and COMMIT.
- IDLE: pos_ready=1; on capture -> PENDING.
- PENDING: pos_ready=0; on frame end (DrawX==H_LAST && DrawY==V_LAST) -> COMMIT.
- COMMIT: copy shadow to cur, pos_ready=0, unconditionally -> IDLE.

REQ-016 A capture coinciding with the frame-end cycle SHALL go to PENDING and wait for the next frame end.
- Positions SHALL never change mid-frame.

REQ-017 Box test SHALL be: tank k is in-box when DrawX >= curk_x && DrawX < curk_x+SPR_DIM, and likewise for Y.
- The sum SHALL be computed 11-bit, so no wrap for positions near 1023.

REQ-018 ROM arbitration: the single ROM port SHALL be granted to tank1 if tank1 is in-box, else to tank2 if tank2 is in-box, else to none.
- Fixed priority, no fairness.

REQ-019 rom_address SHALL be combinational in cycle n: {grant==tank2, DrawY-cury[4:0], DrawX-curx[4:0]}.
- It SHALL be 11'h000 when there is no grant or blank=0.

REQ-020 Grant and blank SHALL be delayed one cycle to align with rom_q.
- Outputs SHALL be registered at the end of cycle n+1, so total latency from DrawX/DrawY is 2 cycles.

REQ-021 Output decode:
- If delayed grant is none or delayed blank=0: pix_hit=0, pix_src=00, pix_idx=0.
- Else pix_src=grant and pix_idx=rom_q.
- pix_hit=1 only if rom_q != TRANSP_IDX.

REQ-022 When both tanks are in-box, a transparent tank1 pixel SHALL yield pix_hit=0; tank2 is not fetched.
- This is an accepted limitation of the single port.

REQ-023 Overlap sticky flag:
- SHALL be set on any cycle with blank=1 and both tanks in-box.
- SHALL be cleared in the cycle after frame end.

REQ-024 collide SHALL pulse high for exactly one cycle, the cycle after frame end, iff the sticky flag was set.
- This includes overlap on the frame-end pixel itself.

REQ-025 Pipeline registers SHALL advance every cycle; there is no stall.

Reset
REQ-026 reset_n=0 SHALL asynchronously force:
- state=IDLE; pos_ready=1 after release.
- cur1=(64,224), cur2=(544,224); shadow registers equal to cur.
- pix_idx=0, pix_hit=0, pix_src=00, collide=0; sticky flag and delay registers 0.

REQ-027 Reset asserted in PENDING SHALL discard the pending update; cur keeps its reset values.

Verification
REQ-028 Bench SHALL cover:
- Reset, then DrawX=70, DrawY=230, blank=1, rom_q=5 at the following cycle -> rom_address=11'h0C6, and 2 cycles later pix_src=01, pix_idx=5, pix_hit=1.
- Overlap: cur1=(100,100), cur2=(110,100), pixel (115,105), rom_q=0 -> rom_address={0,5,15}, pix_hit=0, pix_src=01, and collide=1 one cycle after frame end.
- Handshake: pos_valid=1 with t1=(200,50) mid-frame -> pos_ready falls next cycle; pixel (210,60) misses tank1 until frame end, and pos_ready=1 again two cycles after frame end.
- Boundary: cur2_x=1010 -> no hit for DrawX 0..639; DrawX=cur1_x+31 hits and cur1_x+32 misses.
- blank=0 inside a tank box -> rom_address=0, and outputs 0 two cycles later.
- reset_n pulsed low in PENDING -> outputs clear immediately, and the update is never applied.
